// File: rtl/mdu_hilo_pkg.sv
// Shared MDU definitions: op encodings, default latencies, op field width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mdu_hilo_pkg;

   localparam int unsigned MDU_OP_W     = 4;
   localparam int unsigned MULT_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF  = 10;

   typedef enum logic [MDU_OP_W-1:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MTHI  = 4'd5,
      MDU_MTLO  = 4'd6,
      MDU_MFHI  = 4'd7,
      MDU_MFLO  = 4'd8
   } mdu_op_e;

endpackage

// File: rtl/mdu_hilo_if.sv
// EX-stage <-> MDU bundle: forwarded operands, op/start in; busy, HI/LO, result out.
// Latency: n/a (wires only).
// Backpressure: Busy tells the EX stage to stall md-class instructions.
// Ports: Src1/Src2 operands (rs/rt), MDUOP op code, Start launch pulse,
//        Busy computation in flight, HI/LO register contents, Result mfhi/mflo value.
interface mdu_hilo_if;
   import mdu_hilo_pkg::*;

   logic [31:0]         Src1;
   logic [31:0]         Src2;
   logic [MDU_OP_W-1:0] MDUOP;
   logic                Start;
   logic                Busy;
   logic [31:0]         HI;
   logic [31:0]         LO;
   logic [31:0]         Result;

   // EX stage side
   modport master (
      output Src1, Src2, MDUOP, Start,
      input  Busy, HI, LO, Result
   );

   // MDU side
   modport slave (
      input  Src1, Src2, MDUOP, Start,
      output Busy, HI, LO, Result
   );

endinterface

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers for the EX stage.
// Latency: Busy high exactly MULT_LAT / DIV_LAT cycles after launch; HI/LO update as Busy falls.
// Backpressure: Start or mthi/mtlo while Busy is ignored; hazard logic must stall on Busy|Start.
// Ports: clk (rising edge), rst_n (async active-low), mdu (slave modport of mdu_hilo_if).
module mdu_hilo
   import mdu_hilo_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic     clk,
   input  logic     rst_n,
   mdu_hilo_if.slave mdu
);

   localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      pend_hi_q, pend_hi_d;
   logic [31:0]      pend_lo_q, pend_lo_d;
   logic             pend_wr_q, pend_wr_d;   // cleared for divide-by-zero: commit leaves HI/LO alone
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // ---------------- arithmetic (all combinational) ----------------
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] dvd_s, dvs_s, quo_s, rem_s;
   logic        [31:0] dvs_u, quo_u, rem_u;
   logic               div_zero;
   logic               div_ovf;

   always_comb begin
      prod_s   = $signed({{32{mdu.Src1[31]}}, mdu.Src1}) * $signed({{32{mdu.Src2[31]}}, mdu.Src2});
      prod_u   = {32'd0, mdu.Src1} * {32'd0, mdu.Src2};

      div_zero = (mdu.Src2 == 32'd0);
      // INT_MIN / -1 overflows a 32-bit signed divide; the architected answer is LO=INT_MIN, HI=0.
      div_ovf  = (mdu.Src1 == 32'h8000_0000) && (mdu.Src2 == 32'hFFFF_FFFF);

      // Divisor forced to 1 on zero so the dividers never see x/0; the result is discarded anyway.
      dvs_u    = div_zero ? 32'd1 : mdu.Src2;
      dvd_s    = $signed(mdu.Src1);
      dvs_s    = (div_zero || div_ovf) ? 32'sd1 : $signed(mdu.Src2);

      // SV signed / and % truncate toward zero with remainder taking the dividend's sign.
      quo_s    = dvd_s / dvs_s;
      rem_s    = dvd_s % dvs_s;
      if (div_ovf) begin
         quo_s = 32'sh8000_0000;
         rem_s = 32'sd0;
      end
      quo_u    = mdu.Src1 / dvs_u;
      rem_u    = mdu.Src1 % dvs_u;
   end

   // ---------------- control / next state ----------------
   logic launch;
   logic is_mult;

   always_comb begin
      is_mult = (mdu.MDUOP == MDU_MULT) || (mdu.MDUOP == MDU_MULTU);
      launch  = mdu.Start && !busy_q &&
                ((mdu.MDUOP == MDU_MULT) || (mdu.MDUOP == MDU_MULTU) ||
                 (mdu.MDUOP == MDU_DIV)  || (mdu.MDUOP == MDU_DIVU));

      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;

      if (busy_q) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            if (pend_wr_q) begin
               hi_d = pend_hi_q;
               lo_d = pend_lo_q;
            end
         end
      end else if (launch) begin
         busy_d    = 1'b1;
         cnt_d     = is_mult ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
         pend_wr_d = 1'b1;
         case (mdu.MDUOP)
            MDU_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
            MDU_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
            MDU_DIV: begin
               pend_hi_d = rem_s;
               pend_lo_d = quo_s;
               pend_wr_d = !div_zero;
            end
            default: begin  // MDU_DIVU
               pend_hi_d = rem_u;
               pend_lo_d = quo_u;
               pend_wr_d = !div_zero;
            end
         endcase
      end else if (mdu.MDUOP == MDU_MTHI) begin
         hi_d = mdu.Src1;
      end else if (mdu.MDUOP == MDU_MTLO) begin
         lo_d = mdu.Src1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      mdu.Busy   = busy_q;
      mdu.HI     = hi_q;
      mdu.LO     = lo_q;
      mdu.Result = 32'd0;
      if (mdu.MDUOP == MDU_MFHI)      mdu.Result = hi_q;
      else if (mdu.MDUOP == MDU_MFLO) mdu.Result = lo_q;
   end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: arithmetic, latency, ignore rules, async reset.
module tb_mdu_hilo;
   import mdu_hilo_pkg::*;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   mdu_hilo_if bus();

   mdu_hilo dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mdu   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One clock, then settle 1 time unit past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.Src1  = 32'd0;
      bus.Src2  = 32'd0;
      bus.MDUOP = MDU_NONE;
      bus.Start = 1'b0;
   endtask

   // Count samples with Busy high, starting from the sample right after the launch edge.
   task automatic wait_idle(output int n);
      n = 0;
      while (bus.Busy && n < 100) begin
         step();
         n++;
      end
   endtask

   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.Src1  = a;
      bus.Src2  = b;
      bus.MDUOP = op;
      bus.Start = 1'b1;
      step();
      idle_inputs();
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      launch(op, a, b);
      wait_idle(n);
      check_eq({tag, "_lat"}, n, lat);
      check_eq({tag, "_hi"}, bus.HI, exp_hi);
      check_eq({tag, "_lo"}, bus.LO, exp_lo);
   endtask

   task automatic write_hilo(input logic [3:0] op, input logic [31:0] v);
      bus.MDUOP = op;
      bus.Src1  = v;
      step();
      idle_inputs();
   endtask

   initial begin
      int n;
      n_assert = 0;
      n_fail   = 0;
      idle_inputs();

      // ---- reset ----
      rst_n = 1'b0;
      #1;
      bus.MDUOP = MDU_MFHI;
      #1;
      check_eq("rst_busy", bus.Busy, 32'd0);
      check_eq("rst_hi", bus.HI, 32'd0);
      check_eq("rst_lo", bus.LO, 32'd0);
      check_eq("rst_mfhi", bus.Result, 32'd0);
      bus.MDUOP = MDU_NONE;
      repeat (2) step();
      rst_n = 1'b1;
      step();

      // ---- multiply / divide basics ----
      run_op("mult5x7",  MDU_MULT,  32'd5,          32'd7, 5, 32'd0,          32'd35);
      bus.MDUOP = MDU_MFLO;
      #1;
      check_eq("mflo35", bus.Result, 32'd35);
      idle_inputs();
      run_op("mult_neg", MDU_MULT,  32'hFFFF_FFFF,  32'd2, 5, 32'hFFFF_FFFF,  32'hFFFF_FFFE);
      run_op("multu",    MDU_MULTU, 32'hFFFF_FFFF,  32'd2, 5, 32'h0000_0001,  32'hFFFF_FFFE);

      // mfhi during a division still shows the old HI (1 from multu)
      launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
      bus.MDUOP = MDU_MFHI;
      #1;
      check_eq("mfhi_busy", bus.Result, 32'd1);
      idle_inputs();
      wait_idle(n);
      check_eq("div_neg_lat", n, 10);
      check_eq("div_neg_hi", bus.HI, 32'hFFFF_FFFF);
      check_eq("div_neg_lo", bus.LO, 32'hFFFF_FFFD);

      run_op("divu",     MDU_DIVU,  32'd7,          32'd2, 10, 32'd1,         32'd3);
      run_op("div_ovf",  MDU_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

      // ---- mthi/mtlo then divide by zero ----
      write_hilo(MDU_MTHI, 32'h11);
      write_hilo(MDU_MTLO, 32'h22);
      check_eq("mthi", bus.HI, 32'h11);
      check_eq("mtlo", bus.LO, 32'h22);
      run_op("div0",     MDU_DIV,   32'd5,          32'd0, 10, 32'h11,        32'h22);
      run_op("divu0",    MDU_DIVU,  32'd9,          32'd0, 10, 32'h11,        32'h22);

      // ---- non-launches ----
      bus.MDUOP = MDU_MULT;
      bus.Src1  = 32'd3;
      bus.Src2  = 32'd3;
      step();
      check_eq("op_no_start", bus.Busy, 32'd0);
      bus.MDUOP = 4'd9;
      bus.Start = 1'b1;
      step();
      idle_inputs();
      check_eq("start_bad_op", bus.Busy, 32'd0);
      check_eq("bad_op_hi", bus.HI, 32'h11);

      // ---- Start and mthi while busy are ignored ----
      bus.Src1  = 32'd3;
      bus.Src2  = 32'd4;
      bus.MDUOP = MDU_MULT;
      bus.Start = 1'b1;
      step();                       // launch edge
      n = 0;
      bus.Src1  = 32'd100;
      bus.Src2  = 32'd3;
      bus.MDUOP = MDU_DIV;
      bus.Start = 1'b1;
      step();
      n++;
      bus.Start = 1'b0;
      bus.MDUOP = MDU_MTHI;
      bus.Src1  = 32'hDEAD;
      step();
      n++;
      bus.MDUOP = MDU_MFLO;
      #1;
      check_eq("mflo_busy", bus.Result, 32'h22);
      idle_inputs();
      while (bus.Busy && n < 100) begin
         step();
         n++;
      end
      check_eq("ovl_lat", n, 5);
      check_eq("ovl_hi", bus.HI, 32'd0);
      check_eq("ovl_lo", bus.LO, 32'd12);

      // ---- reset mid-operation ----
      write_hilo(MDU_MTHI, 32'h55);
      launch(MDU_DIV, 32'd100, 32'd7);
      repeat (3) step();
      check_eq("pre_rst_busy", bus.Busy, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", bus.Busy, 32'd0);
      check_eq("mid_rst_hi", bus.HI, 32'd0);
      check_eq("mid_rst_lo", bus.LO, 32'd0);
      step();
      rst_n = 1'b1;
      repeat (12) step();
      bus.MDUOP = MDU_MFLO;
      #1;
      check_eq("post_rst_mflo", bus.Result, 32'd0);
      check_eq("post_rst_busy", bus.Busy, 32'd0);
      check_eq("post_rst_hi", bus.HI, 32'd0);
      idle_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Hard stop so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
